sc_time_controller: RTL
=======================

SC_TIME_CONTROLLER -- requirements
Module: sc_time_controller

Interface
REQ-001 The block SHALL have parameter TIMECTRL_DATAWIDTH, default 8, meaning the width of the seconds count and the limit.
REQ-002 The block SHALL have parameter TIMECTRL_CLKFREQ, default 50000000, meaning clock cycles per one-second tick.
REQ-003 The block SHALL have port SC_TIME_CONTROLLER_CLOCK_50  in  1  single system clock, rising edge.
REQ-004 The block SHALL have port SC_TIME_CONTROLLER_RESET_InLow  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have port SC_TIME_CONTROLLER_START_InHigh  in  1  start/resume request, level sampled each cycle.
REQ-006 The block SHALL have port SC_TIME_CONTROLLER_PAUSE_InHigh  in  1  pause request.
REQ-007 The block SHALL have port SC_TIME_CONTROLLER_CLEAR_InHigh  in  1  synchronous return to IDLE.
REQ-008 The block SHALL have port SC_TIME_CONTROLLER_LIMIT_InBUS  in  DATAWIDTH  time limit in seconds, read live.
REQ-009 The block SHALL have port SC_TIME_CONTROLLER_data_OutBUS  out  DATAWIDTH  elapsed seconds.
REQ-010 The block SHALL have port SC_TIME_CONTROLLER_TICK_OutHigh  out  1  one-cycle pulse per elapsed second.
REQ-011 The block SHALL have port SC_TIME_CONTROLLER_RUNNING_OutHigh  out  1  high only in RUN.
REQ-012 The block SHALL have port SC_TIME_CONTROLLER_TIMEOUT_OutHigh  out  1  high only in DONE.
REQ-013 The block SHALL have port SC_TIME_CONTROLLER_STATE_OutBUS  out  2  state code: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Function
REQ-014 The block SHALL implement a registered FSM with states IDLE, RUN, PAUSE and DONE; request priority SHALL be CLEAR > PAUSE > START.
REQ-015 IDLE: START SHALL go to RUN; if LIMIT==0 when START is sampled, the FSM SHALL go to DONE instead; PAUSE SHALL be ignored.
REQ-016 RUN: PAUSE SHALL go to PAUSE; seconds>=LIMIT SHALL go to DONE the next cycle without a further increment.
REQ-017 PAUSE: START without PAUSE SHALL return to RUN; the prescaler and the seconds count SHALL hold.
REQ-018 DONE: the state SHALL persist until CLEAR; START and PAUSE SHALL be ignored.
REQ-019 CLEAR in any state SHALL go to IDLE with prescaler=0 and seconds=0 at the next edge.
REQ-020 The prescaler SHALL count only in RUN, from 0 to CLKFREQ-1, then wrap to 0, and SHALL assert TICK for exactly that terminal cycle.
REQ-021 Seconds SHALL increment by 1 at the edge following TICK, i.e. data_OutBUS updates one cycle after the terminal count.
REQ-022 Seconds SHALL never wrap; if TICK occurs with seconds at the all-ones value, the count SHALL hold.
REQ-023 If LIMIT is lowered below the current seconds during RUN, the FSM SHALL enter DONE on the next cycle.
REQ-024 In PAUSE, a prescaler value at the terminal count SHALL NOT produce TICK until RUN resumes.
REQ-025 RUNNING, TIMEOUT and STATE SHALL be decoded from the state register only (glitch-free, no input paths).

Reset
REQ-026 Reset assertion SHALL act asynchronously: state=IDLE, prescaler=0, seconds=0, TICK=0, RUNNING=0, TIMEOUT=0, STATE=0.
REQ-027 Reset mid-count SHALL discard all progress; after release the block SHALL wait in IDLE for START.
REQ-028 Reset release SHALL be synchronised externally; the block SHALL make no first-cycle assumption beyond IDLE.

Structure
REQ-029 The state encodings SHALL be defined as constants in shared package sc_time_pkg, reusable by display and game-logic blocks.
REQ-030 The prescaler SHALL be sub-module sc_tick_prescaler (inputs: clock, reset, enable, clear; output: tick), parameterised by CLKFREQ.
REQ-031 The prescaler width SHALL be derived from CLKFREQ via $clog2, with no hard-coded 26-bit width.

Verification (bench uses CLKFREQ=4, DATAWIDTH=8)
REQ-032 LIMIT=3, pulse START -> TICK every 4 cycles, data counts 1,2,3, DONE/TIMEOUT=1 one cycle after data==3, data holds at 3.
REQ-033 LIMIT=10, START, PAUSE after 6 cycles for 20 cycles, then START -> data frozen at 1 during PAUSE, next TICK exactly 2 RUN cycles after resume.
REQ-034 LIMIT=0, START -> DONE next cycle, data=0, TICK never asserted.
REQ-035 RUN with data=5, LIMIT changed 10->4 -> DONE next cycle, data stays 5; CLEAR -> IDLE, data=0.
REQ-036 CLEAR, PAUSE and START asserted together in RUN -> IDLE; PAUSE and START together in RUN -> PAUSE.
REQ-037 Reset low asynchronously mid-RUN (data=2, prescaler=3) -> all outputs 0 immediately, no TICK after release until START.

Source files
------------

// File: rtl/sc_time_pkg.sv
// sc_time_pkg: shared state encodings for the time controller and its consumers
//   (display and game-logic blocks decode STATE_OutBUS with these constants).
package sc_time_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_RUN   = 2'd1;
  localparam logic [1:0] STATE_PAUSE = 2'd2;
  localparam logic [1:0] STATE_DONE  = 2'd3;
  function automatic int presc_width(input int clkfreq);
    return (clkfreq > 1) ? $clog2(clkfreq) : 1;
  endfunction
endpackage

// File: rtl/sc_tick_prescaler.sv
// sc_tick_prescaler: divides the clock down to a one-cycle tick every CLKFREQ enabled cycles
//   i_clk     : system clock, rising edge
//   i_rst_n   : asynchronous active-low reset
//   i_enable  : count only while high; also gates o_tick
//   i_clear   : synchronous return of the count to 0 (wins over i_enable)
//   o_tick    : high during the terminal-count cycle while enabled
module sc_tick_prescaler
  import sc_time_pkg::*;
#(
  parameter int CLKFREQ = 50000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_tick
);
  localparam int W = presc_width(CLKFREQ);
  localparam logic [W-1:0] TERM = W'(CLKFREQ - 1);
  logic [W-1:0] r_cnt;
  // a held terminal count stays silent until counting resumes
  assign o_tick = i_enable && (r_cnt == TERM);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_enable) r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/sc_time_controller.sv
// sc_time_controller: start/pause/clear seconds counter with limit-driven timeout
//   SC_TIME_CONTROLLER_CLOCK_50        : clock, rising edge
//   SC_TIME_CONTROLLER_RESET_InLow     : asynchronous active-low reset
//   SC_TIME_CONTROLLER_START_InHigh    : start/resume request
//   SC_TIME_CONTROLLER_PAUSE_InHigh    : pause request
//   SC_TIME_CONTROLLER_CLEAR_InHigh    : synchronous return to IDLE
//   SC_TIME_CONTROLLER_LIMIT_InBUS     : limit in seconds, read live
//   SC_TIME_CONTROLLER_data_OutBUS     : elapsed seconds
//   SC_TIME_CONTROLLER_TICK_OutHigh    : one-cycle pulse per elapsed second
//   SC_TIME_CONTROLLER_RUNNING_OutHigh : high in RUN
//   SC_TIME_CONTROLLER_TIMEOUT_OutHigh : high in DONE
//   SC_TIME_CONTROLLER_STATE_OutBUS    : IDLE=0 RUN=1 PAUSE=2 DONE=3
module sc_time_controller
  import sc_time_pkg::*;
#(
  parameter int TIMECTRL_DATAWIDTH = 8,
  parameter int TIMECTRL_CLKFREQ   = 50000000
) (
  input  logic                          SC_TIME_CONTROLLER_CLOCK_50,
  input  logic                          SC_TIME_CONTROLLER_RESET_InLow,
  input  logic                          SC_TIME_CONTROLLER_START_InHigh,
  input  logic                          SC_TIME_CONTROLLER_PAUSE_InHigh,
  input  logic                          SC_TIME_CONTROLLER_CLEAR_InHigh,
  input  logic [TIMECTRL_DATAWIDTH-1:0] SC_TIME_CONTROLLER_LIMIT_InBUS,
  output logic [TIMECTRL_DATAWIDTH-1:0] SC_TIME_CONTROLLER_data_OutBUS,
  output logic                          SC_TIME_CONTROLLER_TICK_OutHigh,
  output logic                          SC_TIME_CONTROLLER_RUNNING_OutHigh,
  output logic                          SC_TIME_CONTROLLER_TIMEOUT_OutHigh,
  output logic [1:0]                    SC_TIME_CONTROLLER_STATE_OutBUS
);
  state_t r_state, w_next;
  logic [TIMECTRL_DATAWIDTH-1:0] r_sec;
  logic w_tick, w_at_limit, w_start, w_pause, w_clear;
  assign w_start    = SC_TIME_CONTROLLER_START_InHigh;
  assign w_pause    = SC_TIME_CONTROLLER_PAUSE_InHigh;
  assign w_clear    = SC_TIME_CONTROLLER_CLEAR_InHigh;
  assign w_at_limit = r_sec >= SC_TIME_CONTROLLER_LIMIT_InBUS;
  sc_tick_prescaler #(.CLKFREQ(TIMECTRL_CLKFREQ)) u_presc (
    .i_clk    (SC_TIME_CONTROLLER_CLOCK_50),
    .i_rst_n  (SC_TIME_CONTROLLER_RESET_InLow),
    .i_enable (r_state == ST_RUN),
    .i_clear  (w_clear),
    .o_tick   (w_tick)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = w_start ? ((SC_TIME_CONTROLLER_LIMIT_InBUS == '0) ? ST_DONE : ST_RUN) : ST_IDLE;
      ST_RUN:   w_next = w_pause ? ST_PAUSE : (w_at_limit ? ST_DONE : ST_RUN);
      ST_PAUSE: w_next = (w_start && !w_pause) ? ST_RUN : ST_PAUSE;
      default:  w_next = ST_DONE;
    endcase
    if (w_clear) w_next = ST_IDLE;
  end
  always_ff @(posedge SC_TIME_CONTROLLER_CLOCK_50 or negedge SC_TIME_CONTROLLER_RESET_InLow) begin
    if (!SC_TIME_CONTROLLER_RESET_InLow) r_state <= ST_IDLE;
    else r_state <= w_next;
  end
  // a tick landing on the limit-reached cycle must not push the count past it
  always_ff @(posedge SC_TIME_CONTROLLER_CLOCK_50 or negedge SC_TIME_CONTROLLER_RESET_InLow) begin
    if (!SC_TIME_CONTROLLER_RESET_InLow) r_sec <= '0;
    else if (w_clear) r_sec <= '0;
    else if (w_tick && !w_at_limit && (r_sec != '1)) r_sec <= r_sec + 1'b1;
  end
  assign SC_TIME_CONTROLLER_data_OutBUS     = r_sec;
  assign SC_TIME_CONTROLLER_TICK_OutHigh    = w_tick;
  assign SC_TIME_CONTROLLER_RUNNING_OutHigh = r_state == ST_RUN;
  assign SC_TIME_CONTROLLER_TIMEOUT_OutHigh = r_state == ST_DONE;
  assign SC_TIME_CONTROLLER_STATE_OutBUS    = r_state;
endmodule
